// File: rtl/sap3_pkg.sv
// Shared SAP3 definitions: register-file ext encodings, arbiter states, requester ids and
// default widths.
package sap3_pkg;

    localparam int SAP3_DATA_W = 16;
    localparam int SAP3_SEL_W  = 5;

    typedef enum logic [1:0] {
        EXT_NONE = 2'b00,
        EXT_INC  = 2'b01,
        EXT_DEC  = 2'b10,
        EXT_INC2 = 2'b11
    } ext_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_OWN_A = 2'b01,
        ARB_OWN_B = 2'b10
    } arb_state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/regfile_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin choice. An owner excludes the other requester;
// with no owner, a tie goes to whichever requester did not win last.
module rr_pick2
    import sap3_pkg::*;
(
    input  logic       a_req,
    input  logic       b_req,
    input  logic       last,
    input  arb_state_e owner,
    output logic       pick_a,
    output logic       pick_b
);

    always_comb begin
        pick_a = 1'b0;
        pick_b = 1'b0;
        case (owner)
            ARB_OWN_A: pick_a = a_req;
            ARB_OWN_B: pick_b = b_req;
            default: begin
                if (a_req && b_req) begin
                    pick_a = (last == REQ_B);
                    pick_b = (last == REQ_A);
                end else begin
                    pick_a = a_req;
                    pick_b = b_req;
                end
            end
        endcase
    end

endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester arbiter and command mux in front of the SAP3 register file.
// Define REGFILE_ARB_LOCK_EN to add the multi-cycle ownership lock (OWN_A/OWN_B + hold counter).
module regfile_arbiter
    import sap3_pkg::*;
#(
    parameter int DATA_W   = SAP3_DATA_W,
    parameter int SEL_W    = SAP3_SEL_W,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req,
    input  logic              a_lock,
    input  logic [SEL_W-1:0]  a_rd_sel,
    input  logic [SEL_W-1:0]  a_wr_sel,
    input  logic [1:0]        a_ext,
    input  logic              a_we,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_lock,
    input  logic [SEL_W-1:0]  b_rd_sel,
    input  logic [SEL_W-1:0]  b_wr_sel,
    input  logic [1:0]        b_ext,
    input  logic              b_we,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic [SEL_W-1:0]  rf_rd_sel,
    output logic [SEL_W-1:0]  rf_wr_sel,
    output logic [1:0]        rf_ext,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_out
);

    arb_state_e owner;
    logic       last;
    logic       pick_a;
    logic       pick_b;

    rr_pick2 u_pick (
        .a_req  (a_req),
        .b_req  (b_req),
        .last   (last),
        .owner  (owner),
        .pick_a (pick_a),
        .pick_b (pick_b)
    );

    // A command presented while reset is held is never issued.
    assign a_gnt = rst & pick_a;
    assign b_gnt = rst & pick_b;

    // Idle command must carry ext=NONE: the register file acts on ext even without we.
    always_comb begin
        rf_rd_sel  = '0;
        rf_wr_sel  = '0;
        rf_ext     = EXT_NONE;
        rf_we      = 1'b0;
        rf_data_in = '0;
        if (a_gnt) begin
            rf_rd_sel  = a_rd_sel;
            rf_wr_sel  = a_wr_sel;
            rf_ext     = a_ext;
            rf_we      = a_we;
            rf_data_in = a_wdata;
        end else if (b_gnt) begin
            rf_rd_sel  = b_rd_sel;
            rf_wr_sel  = b_wr_sel;
            rf_ext     = b_ext;
            rf_we      = b_we;
            rf_data_in = b_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last     <= REQ_B;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= a_gnt;
            b_rvalid <= b_gnt;
            if (a_gnt) begin
                a_rdata <= rf_data_out;
                last    <= REQ_A;
            end
            if (b_gnt) begin
                b_rdata <= rf_data_out;
                last    <= REQ_B;
            end
        end
    end

`ifdef REGFILE_ARB_LOCK_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_inc;

    assign hold_inc = (hold == HOLD_MAX) ? hold : hold + HOLD_W'(1);

    // hold counts every grant of the current ownership run, including the acquiring one,
    // so a contended owner gets exactly MAX_HOLD consecutive grants.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner <= ARB_IDLE;
            hold  <= '0;
        end else begin
            case (owner)
                ARB_OWN_A: begin
                    if (a_gnt) begin
                        hold <= hold_inc;
                        if (!a_lock || (hold_inc == HOLD_MAX && b_req)) owner <= ARB_IDLE;
                    end else if (!a_lock) begin
                        owner <= ARB_IDLE;
                    end
                end
                ARB_OWN_B: begin
                    if (b_gnt) begin
                        hold <= hold_inc;
                        if (!b_lock || (hold_inc == HOLD_MAX && a_req)) owner <= ARB_IDLE;
                    end else if (!b_lock) begin
                        owner <= ARB_IDLE;
                    end
                end
                default: begin
                    hold <= HOLD_W'(1);
                    if (a_gnt && a_lock)      owner <= ARB_OWN_A;
                    else if (b_gnt && b_lock) owner <= ARB_OWN_B;
                    else                      owner <= ARB_IDLE;
                end
            endcase
        end
    end
`else
    localparam int unused_max_hold = MAX_HOLD;
    logic unused_lock;

    assign unused_lock = a_lock ^ b_lock;
    assign owner       = ARB_IDLE;
`endif

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized scoreboard bench for regfile_arbiter with a register-file stub and a
// reference model of the arbitration rules.
module tb_regfile_arbiter;

    localparam int DATA_W   = 16;
    localparam int SEL_W    = 5;
    localparam int MAX_HOLD = 4;

    typedef struct packed {
        logic        req;
        logic        lock;
        logic [4:0]  rd;
        logic [4:0]  wr;
        logic [1:0]  ext;
        logic        we;
        logic [15:0] wd;
    } cmd_t;

    typedef struct {
        int          cyc;
        logic [1:0]  gnt;
        logic [28:0] bus;
        logic        clr;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic              a_req = 0, a_lock = 0, a_we = 0;
    logic [SEL_W-1:0]  a_rd_sel = '0, a_wr_sel = '0;
    logic [1:0]        a_ext = '0;
    logic [DATA_W-1:0] a_wdata = '0;
    logic              a_gnt, a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req = 0, b_lock = 0, b_we = 0;
    logic [SEL_W-1:0]  b_rd_sel = '0, b_wr_sel = '0;
    logic [1:0]        b_ext = '0;
    logic [DATA_W-1:0] b_wdata = '0;
    logic              b_gnt, b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic [SEL_W-1:0]  rf_rd_sel, rf_wr_sel;
    logic [1:0]        rf_ext;
    logic              rf_we;
    logic [DATA_W-1:0] rf_data_in, rf_data_out;

    always #5 clk = ~clk;

    regfile_arbiter #(.DATA_W(DATA_W), .SEL_W(SEL_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_lock(a_lock), .a_rd_sel(a_rd_sel), .a_wr_sel(a_wr_sel),
        .a_ext(a_ext), .a_we(a_we), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_lock(b_lock), .b_rd_sel(b_rd_sel), .b_wr_sel(b_wr_sel),
        .b_ext(b_ext), .b_we(b_we), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .rf_rd_sel(rf_rd_sel), .rf_wr_sel(rf_wr_sel), .rf_ext(rf_ext), .rf_we(rf_we),
        .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
    );

    function automatic logic [15:0] init_val(int i);
        if (i == 18) return 16'h3456;
        if (i == 3)  return 16'h0055;
        return 16'(i * 257 + 4096);
    endfunction

    function automatic logic [15:0] apply(logic [15:0] v, logic we, logic [1:0] ext, logic [15:0] wd);
        if (we) return wd;
        case (ext)
            2'b01:   return v + 16'd1;
            2'b10:   return v - 16'd1;
            2'b11:   return v + 16'd2;
            default: return v;
        endcase
    endfunction

    // Register-file stub: combinational read, commit at the edge, reloads while reset is low.
    logic [15:0] rf_mem [32];
    assign rf_data_out = rf_mem[rf_rd_sel];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
        end else begin
            rf_mem[rf_wr_sel] <= apply(rf_mem[rf_wr_sel], rf_we, rf_ext, rf_data_in);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner 0=none 1=A 2=B, last winner, length of current ownership run.
    exp_t        exp_q [$];
    rd_t         rdq_a [$];
    rd_t         rdq_b [$];
    logic [15:0] ref_mem [32];
    int          m_owner = 0;
    int          m_last  = 2;
    int          m_run   = 0;
    int          cyc_n   = 0;
    logic        prev_r  = 1'b0;

    task automatic step(input logic r, input cmd_t ca, input cmd_t cb);
        int   win;
        exp_t e;
        rd_t  rd;
        logic own_lock, other_req;
        @(posedge clk);
        #1;
        rst = r;
        a_req = ca.req; a_lock = ca.lock; a_rd_sel = ca.rd; a_wr_sel = ca.wr;
        a_ext = ca.ext; a_we = ca.we; a_wdata = ca.wd;
        b_req = cb.req; b_lock = cb.lock; b_rd_sel = cb.rd; b_wr_sel = cb.wr;
        b_ext = cb.ext; b_we = cb.we; b_wdata = cb.wd;

        if (!r)                         win = 0;
        else if (m_owner == 1)          win = ca.req ? 1 : 0;
        else if (m_owner == 2)          win = cb.req ? 2 : 0;
        else if (ca.req && cb.req)      win = (m_last == 1) ? 2 : 1;
        else                            win = ca.req ? 1 : (cb.req ? 2 : 0);

        e.cyc = cyc_n;
        e.gnt = {win == 1, win == 2};
        e.clr = !prev_r;
        e.bus = '0;
        if (win == 1) begin
            e.bus = {ca.rd, ca.wr, ca.ext, ca.we, ca.wd};
            rd.cyc = cyc_n + 1; rd.val = ref_mem[ca.rd];
            rdq_a.push_back(rd);
            ref_mem[ca.wr] = apply(ref_mem[ca.wr], ca.we, ca.ext, ca.wd);
        end else if (win == 2) begin
            e.bus = {cb.rd, cb.wr, cb.ext, cb.we, cb.wd};
            rd.cyc = cyc_n + 1; rd.val = ref_mem[cb.rd];
            rdq_b.push_back(rd);
            ref_mem[cb.wr] = apply(ref_mem[cb.wr], cb.we, cb.ext, cb.wd);
        end
        exp_q.push_back(e);

`ifdef REGFILE_ARB_LOCK_EN
        if (r) begin
            if (m_owner == 0) begin
                if (win == 1 && ca.lock)      begin m_owner = 1; m_run = 1; end
                else if (win == 2 && cb.lock) begin m_owner = 2; m_run = 1; end
            end else begin
                own_lock  = (m_owner == 1) ? ca.lock : cb.lock;
                other_req = (m_owner == 1) ? cb.req  : ca.req;
                if (win != 0) begin
                    m_run = (m_run < MAX_HOLD) ? m_run + 1 : MAX_HOLD;
                    if (!own_lock || (m_run == MAX_HOLD && other_req)) m_owner = 0;
                end else if (!own_lock) begin
                    m_owner = 0;
                end
            end
        end
`else
        own_lock  = 1'b0;
        other_req = 1'b0;
`endif
        if (win != 0) m_last = win;
        if (!r) begin
            m_owner = 0; m_last = 2; m_run = 0;
            for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
        end
        prev_r = r;
        cyc_n++;
    endtask

    // Monitor: one command expectation per cycle, read data popped when rvalid is due.
    exp_t        mon_e;
    logic [15:0] held_a = '0;
    logic [15:0] held_b = '0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("gnt", {a_gnt, b_gnt}, mon_e.gnt);
            check("rf_cmd", {rf_rd_sel, rf_wr_sel, rf_ext, rf_we, rf_data_in}, mon_e.bus);
            if (mon_e.clr) begin
                held_a = '0;
                held_b = '0;
            end
            if (rdq_a.size() > 0 && rdq_a[0].cyc == mon_e.cyc) begin
                check("a_rvalid", a_rvalid, 1);
                held_a = rdq_a[0].val;
                void'(rdq_a.pop_front());
            end else begin
                check("a_rvalid", a_rvalid, 0);
            end
            if (rdq_b.size() > 0 && rdq_b[0].cyc == mon_e.cyc) begin
                check("b_rvalid", b_rvalid, 1);
                held_b = rdq_b[0].val;
                void'(rdq_b.pop_front());
            end else begin
                check("b_rvalid", b_rvalid, 0);
            end
            check("a_rdata", a_rdata, held_a);
            check("b_rdata", b_rdata, held_b);
        end
    end

    function automatic cmd_t mk(logic req, logic lock, logic [4:0] rd, logic [4:0] wr,
                                logic [1:0] ext, logic we, logic [15:0] wd);
        return {req, lock, rd, wr, ext, we, wd};
    endfunction

    function automatic cmd_t rand_cmd();
        return mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  5'($urandom), 5'($urandom), 2'($urandom), 1'($urandom), 16'($urandom));
    endfunction

    cmd_t idle_c;
    cmd_t ca, cb;

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
        idle_c = mk(0, 0, 0, 0, 2'b00, 0, 0);

        repeat (2) step(0, idle_c, idle_c);

        // Single requester reads pair 0x12.
        step(1, mk(1, 0, 5'h12, 0, 2'b00, 0, 0), idle_c);
        step(1, idle_c, idle_c);

        // Same-cycle write and read of register 3, then read it back.
        step(1, mk(1, 0, 5'd3, 5'd3, 2'b00, 1, 16'h00AA), idle_c);
        step(1, mk(1, 0, 5'd3, 5'd0, 2'b00, 0, 0), idle_c);

        // Both requesting continuously without lock.
        step(0, idle_c, idle_c);
        for (int i = 0; i < 8; i++)
            step(1, mk(1, 0, 5'($urandom), 5'd7, 2'($urandom), 0, 0),
                    mk(1, 0, 5'($urandom), 5'd9, 2'($urandom), 0, 0));

        // Nobody requesting while both carry ext=INC.
        for (int i = 0; i < 10; i++)
            step(1, mk(0, 0, 5'd1, 5'd1, 2'b01, 1, 16'hFFFF), mk(0, 0, 5'd2, 5'd2, 2'b01, 1, 16'hFFFF));

        // A holds the lock while B keeps requesting.
        step(0, idle_c, idle_c);
        for (int i = 0; i < 8; i++)
            step(1, mk(1, 1, 5'd4, 5'd4, 2'b01, 0, 0), mk(1, 0, 5'd5, 5'd5, 2'b10, 0, 0));

        // A locked, drops req for a cycle with lock still high, then releases.
        step(0, idle_c, idle_c);
        step(1, mk(1, 1, 5'd6, 5'd6, 2'b00, 0, 0), idle_c);
        step(1, mk(0, 1, 5'd6, 5'd6, 2'b11, 0, 0), mk(1, 0, 5'd8, 5'd8, 2'b01, 0, 0));
        step(1, mk(0, 0, 5'd6, 5'd6, 2'b11, 0, 0), mk(1, 0, 5'd8, 5'd8, 2'b01, 0, 0));
        step(1, idle_c, mk(1, 0, 5'd8, 5'd8, 2'b01, 0, 0));

        // Reset while A owns, then a tie right after release.
        step(1, mk(1, 1, 5'd10, 5'd10, 2'b00, 0, 0), mk(1, 0, 5'd11, 5'd11, 2'b00, 0, 0));
        step(0, mk(1, 1, 5'd10, 5'd10, 2'b01, 0, 0), mk(1, 0, 5'd11, 5'd11, 2'b01, 0, 0));
        step(1, mk(1, 0, 5'd12, 5'd12, 2'b00, 0, 0), mk(1, 0, 5'd13, 5'd13, 2'b00, 0, 0));
        step(1, idle_c, idle_c);

        for (int i = 0; i < 400; i++) begin
            ca = rand_cmd();
            cb = rand_cmd();
            step($urandom_range(0, 49) != 0, ca, cb);
        end

        repeat (3) step(1, idle_c, idle_c);
        repeat (2) @(posedge clk);
        @(negedge clk);

        check("exp_q_drain", exp_q.size(), 0);
        check("rdq_drain", rdq_a.size() + rdq_b.size(), 0);
        for (int i = 0; i < 32; i++) check("rf_contents", rf_mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
